// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: packet-aware weighted round-robin merge of two valid/ready streams
module fifo_rr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int WEIGHT0 = 1,
  parameter int WEIGHT1 = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i0_valid,
  output logic              i0_ready,
  input  logic [DATA_W-1:0] i0_data,
  input  logic              i0_last,
  input  logic              i1_valid,
  output logic              i1_ready,
  input  logic [DATA_W-1:0] i1_data,
  input  logic              i1_last,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_src,
  output logic [31:0]       pkt_cnt0,
  output logic [31:0]       pkt_cnt1
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  localparam logic [3:0] W0 = 4'(WEIGHT0);
  localparam logic [3:0] W1 = 4'(WEIGHT1);
  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic [3:0] credit_q, credit_d, cdec;
  logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic o_valid_q, o_last_q, o_src_q;
  logic [DATA_W-1:0] o_data_q;
  logic can_load, src, acc, in_last;
  logic [DATA_W-1:0] in_data;
  assign can_load = !o_valid_q || o_ready;
  assign i0_ready = (state_q == BUSY0) && can_load;
  assign i1_ready = (state_q == BUSY1) && can_load;
  assign src      = (state_q == BUSY1);
  assign acc      = (i0_valid && i0_ready) || (i1_valid && i1_ready);
  assign in_last  = src ? i1_last : i0_last;
  assign in_data  = src ? i1_data : i0_data;
  assign cdec     = credit_q - 4'd1;
  assign o_valid  = o_valid_q;
  assign o_data   = o_data_q;
  assign o_last   = o_last_q;
  assign o_src    = o_src_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
  // grant selection, packet completion, credit consumption and pointer rotation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    case (state_q)
      IDLE: begin
        if (i0_valid && i1_valid) state_d = ptr_q ? BUSY1 : BUSY0;
        else if (i0_valid)        state_d = BUSY0;
        else if (i1_valid)        state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (acc && in_last) begin
          state_d = IDLE;
          cnt0_d  = src ? cnt0_q : cnt0_q + 32'd1;
          cnt1_d  = src ? cnt1_q + 32'd1 : cnt1_q;
          // only a grant won through the pointer spends that input's credit
          if (src == ptr_q) begin
            credit_d = (cdec == 4'd0) ? (ptr_q ? W0 : W1) : cdec;
            ptr_d    = (cdec == 4'd0) ? ~ptr_q : ptr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // arbitration state and packet counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      credit_q <= W0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end
  // single output register, loads whenever empty or being drained
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= 1'b0;
    end else if (can_load) begin
      o_valid_q <= acc;
      if (acc) begin
        o_data_q <= in_data;
        o_last_q <= in_last;
        o_src_q  <= src;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed stimulus with per-source scoreboard and grant-order queue
module tb_fifo_rr_arbiter;
  logic clk = 1'b0, rstn = 1'b0;
  logic i0_valid = 1'b0, i0_last = 1'b0, i1_valid = 1'b0, i1_last = 1'b0, o_ready = 1'b1;
  logic [31:0] i0_data = '0, i1_data = '0;
  logic i0_ready, i1_ready, o_valid, o_last, o_src;
  logic [31:0] o_data, pkt_cnt0, pkt_cnt1;
  int checks = 0, errors = 0, cyc = 0;
  logic [32:0] q0[$], q1[$];
  logic oq[$];

  fifo_rr_arbiter #(.DATA_W(32), .WEIGHT0(2), .WEIGHT1(1)) dut (
    .clk(clk), .rstn(rstn),
    .i0_valid(i0_valid), .i0_ready(i0_ready), .i0_data(i0_data), .i0_last(i0_last),
    .i1_valid(i1_valid), .i1_ready(i1_ready), .i1_data(i1_data), .i1_last(i1_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last), .o_src(o_src),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every accepted output beat is compared with the head of its source queue
  always @(negedge clk) begin
    logic [32:0] e;
    if (rstn && o_valid && o_ready) begin
      if ((o_src ? q1.size() : q0.size()) == 0) chk("unexpected_beat", o_data, 32'hDEAD);
      else begin
        e = o_src ? q1.pop_front() : q0.pop_front();
        chk("beat_data", o_data, e[31:0]);
        chk("beat_last", 32'(o_last), 32'(e[32]));
        if (o_last && oq.size() > 0) chk("grant_order", 32'(o_src), 32'(oq.pop_front()));
      end
    end
  end

  task automatic send(input bit s, input int n, input logic [31:0] base, input bit ord);
    bit acc, l;
    int w;
    logic [31:0] d;
    if (ord) oq.push_back(s);
    for (int k = 0; k < n; k++) begin
      d = base + 32'(k);
      l = (k == n - 1);
      if (s) begin i1_valid = 1'b1; i1_data = d; i1_last = l; q1.push_back({l, d}); end
      else   begin i0_valid = 1'b1; i0_data = d; i0_last = l; q0.push_back({l, d}); end
      acc = 1'b0;
      w = 0;
      while (!acc && rstn && w < 100) begin
        @(negedge clk);
        acc = s ? (i1_valid && i1_ready) : (i0_valid && i0_ready);
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        if (rstn) chk("accept_timeout", 32'(w), 32'd0);
        break;
      end
    end
    if (s) i1_valid = 1'b0; else i0_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q0.size() + q1.size() + oq.size()) != 0 && w < 50) begin @(posedge clk); w++; end
    #1;
    chk("drain", 32'(q0.size() + q1.size() + oq.size()), 32'd0);
  endtask

  initial begin
    int c0;
    logic [31:0] hold;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_src", 32'(o_src), 32'd0);
    chk("rst_cnt0", pkt_cnt0, 32'd0);
    chk("rst_cnt1", pkt_cnt1, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    // weighted rotation 2:1 with both inputs always valid, one bubble per packet
    for (int i = 0; i < 6; i++) oq.push_back((i % 3) == 2);
    c0 = cyc;
    fork
      for (int i = 0; i < 4; i++) send(1'b0, 1, 32'hA000 + 32'(i), 1'b0);
      for (int i = 0; i < 2; i++) send(1'b1, 1, 32'hB000 + 32'(i), 1'b0);
    join
    chk("weighted_cycles", 32'(cyc - c0), 32'd12);
    drain();
    chk("w_cnt0", pkt_cnt0, 32'd4);
    chk("w_cnt1", pkt_cnt1, 32'd2);
    // three-beat packet from input 0
    send(1'b0, 3, 32'h0000_00A0, 1'b1);
    chk("p3_last_data", o_data, 32'h0000_00A2);
    chk("p3_last_flag", 32'(o_last), 32'd1);
    drain();
    chk("p3_cnt0", pkt_cnt0, 32'd5);
    // input 1 alone, pointer left on input 0
    for (int i = 0; i < 5; i++) send(1'b1, 1, 32'hC000 + 32'(i), 1'b1);
    drain();
    chk("solo_cnt1", pkt_cnt1, 32'd7);
    oq.push_back(1'b0);
    oq.push_back(1'b1);
    fork
      send(1'b0, 1, 32'hD000, 1'b0);
      send(1'b1, 1, 32'hD100, 1'b0);
    join
    drain();
    chk("both_cnt0", pkt_cnt0, 32'd6);
    chk("both_cnt1", pkt_cnt1, 32'd8);
    // downstream stall mid-packet
    fork
      send(1'b0, 4, 32'hE000, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 o_ready = 1'b0;
        hold = o_data;
        repeat (4) begin
          @(negedge clk);
          chk("stall_valid", 32'(o_valid), 32'd1);
          chk("stall_data", o_data, hold);
          chk("stall_i0_ready", 32'(i0_ready), 32'd0);
        end
        @(posedge clk); #1 o_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cnt0", pkt_cnt0, 32'd7);
    // input 1 waits for input 0's packet plus the idle cycle
    oq.push_back(1'b0);
    oq.push_back(1'b1);
    fork
      send(1'b0, 3, 32'hF000, 1'b0);
      begin
        @(posedge clk); #1;
        send(1'b1, 1, 32'hF100, 1'b0);
      end
      begin
        repeat (5) begin @(negedge clk); chk("wait_i1_ready_low", 32'(i1_ready), 32'd0); end
        @(negedge clk);
        chk("wait_i1_ready_high", 32'(i1_ready), 32'd1);
      end
    join
    drain();
    chk("wait_cnt0", pkt_cnt0, 32'd8);
    chk("wait_cnt1", pkt_cnt1, 32'd9);
    // asynchronous reset in the middle of a packet
    fork
      send(1'b0, 4, 32'h1000, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("arst_o_valid", 32'(o_valid), 32'd0);
        chk("arst_cnt0", pkt_cnt0, 32'd0);
        chk("arst_cnt1", pkt_cnt1, 32'd0);
        q0.delete();
        q1.delete();
        oq.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
      end
    join
    @(posedge clk); #1;
    send(1'b0, 2, 32'h2000, 1'b1);
    drain();
    chk("post_rst_cnt0", pkt_cnt0, 32'd1);
    // counter wrap
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1 release dut.cnt0_q;
    chk("preload_cnt0", pkt_cnt0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send(1'b0, 1, 32'h3000, 1'b1);
    drain();
    chk("wrap_cnt0", pkt_cnt0, 32'd0);
    chk("wrap_cnt1", pkt_cnt1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Two-requester, packet-aware, weighted round-robin arbiter that merges two valid/ready FIFO streams onto one shared output stream. It sits in front of the shared downstream fifo port of sub_block-style datapaths and owns the sequencing of which input may drive it. Once a grant is issued it is held until the last beat of the packet. Per-input packet counters are exposed for status.

Parameters:
DATA_W, 32, width of the data bus on all streams
WEIGHT0, 1, packets granted to input 0 per round before priority rotates (1..15)
WEIGHT1, 1, packets granted to input 1 per round before priority rotates (1..15)

Ports:
clk  input  1  single clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
i0_valid  input  1  input 0 beat valid
i0_ready  output  1  input 0 beat accepted
i0_data  input  DATA_W  input 0 data
i0_last  input  1  input 0 last beat of packet
i1_valid  input  1  input 1 beat valid
i1_ready  output  1  input 1 beat accepted
i1_data  input  DATA_W  input 1 data
i1_last  input  1  input 1 last beat of packet
o_valid  output  1  output beat valid (registered)
o_ready  input  1  downstream accepts beat
o_data  output  DATA_W  output data (registered)
o_last  output  1  output last (registered)
o_src  output  1  source index of current output beat (registered)
pkt_cnt0  output  32  packets forwarded from input 0 (wraps)
pkt_cnt1  output  32  packets forwarded from input 1 (wraps)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. clk and rstn are the port names.
- Reset values: o_valid=0, o_data=0, o_last=0, o_src=0, pkt_cnt0/1=0, state=IDLE, priority pointer=0, credit=WEIGHT0.
- Reset mid-packet drops the partial packet; there is no recovery beyond the reset values.
- Handshake: a beat transfers on valid&&ready. Once asserted, valid and data are held by the source until the beat is accepted.
- Output stage: a single register. can_load = !o_valid || o_ready.
- i0_ready = (state==BUSY0) && can_load. i1_ready = (state==BUSY1) && can_load. Both are never high together.
- Latency: an input beat accepted in cycle N appears on o_* in cycle N+1. Full throughput within a packet.
- FSM IDLE:
  - Neither input valid: stay.
  - Only one input valid: go BUSY to that input (work-conserving).
  - Both valid: go BUSY to the input named by the priority pointer.
  - No beat is accepted in IDLE, so there is one bubble cycle between packets.
- FSM BUSYn: accept beats from input n only.
  - On an accepted beat with in_last=1: go IDLE, increment pkt_cntn, decrement credit.
  - If credit reaches 0 after the decrement: pointer switches to the other input and credit reloads with that input's weight.
  - Grant entered without the pointer (other input idle): the pointer and credit for the pointed-to input are untouched.
  - The granted input is never preempted; other-input valid is ignored until last.
- Output backpressure: when o_ready=0 with o_valid=1, o_* hold stable and the granted input's ready is 0.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0. They increment in the cycle the last beat is accepted on the input side.
- Single-beat packets (valid with last=1 on the first beat) are legal and take 2 cycles per packet per input.
- Simultaneous events: valid on both inputs in IDLE is resolved by the pointer only. A pointer update and a new IDLE decision never occur in the same cycle.

Test Plan:
- Reset, then i0 sends 3-beat packet {A,B,C} with o_ready=1 -> o_data A,B,C on cycles 2,3,4 after i0_valid rises, o_last on C, o_src=0, pkt_cnt0=1.
- Both inputs continuously valid with 1-beat packets, WEIGHT0=2, WEIGHT1=1 -> output source sequence 0,0,1,0,0,1, one idle cycle between packets.
- Only i1 active for 5 packets (WEIGHT1=1) -> all 5 granted to i1, pkt_cnt1=5, pointer unchanged for i0's turn. i0 then requests together with i1 -> i0 is granted next.
- o_ready held low 4 cycles mid-packet -> o_data stable, i0_ready=0 throughout, no beats lost or duplicated, order preserved.
- i1 asserts valid while an i0 packet is in progress -> i1_ready stays 0 until the cycle after i0's last beat plus the IDLE cycle.
- rstn asserted low mid-packet, asynchronously between clock edges -> o_valid=0 immediately, counters=0. After release, a new packet forwards cleanly.
- pkt_cnt0 forced/preloaded to 0xFFFFFFFF, then one i0 packet sent -> pkt_cnt0=0.
